// File: rtl/uart_tx.sv
// Serial byte transmitter: 8N1 frames, LSB first, bit timing from the shared tick_in strobe; optional FIFO via UART_TX_FIFO_EN.
// Latency: start bit on the first tick_in edge after the byte is buffered (>= 1 clk after accept); frame = 10*TICKS_PER_BIT strobes.
// Backpressure: tx_ready is low while the buffer is full (holding register, or FIFO_DEPTH entries); depends only on registered state.
module uart_tx #(
    parameter int TICKS_PER_BIT = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dcom,
    output logic       busy
);

    localparam int CNT_W = $clog2(TICKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 64 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx: parameter out of range");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;

    logic       buf_vld;
    logic [7:0] buf_dat;
    logic       push;
    logic       pop;
    logic       bit_end;

    assign push    = tx_valid && tx_ready;
    assign bit_end = tick_in && (tick_cnt == CNT_W'(TICKS_PER_BIT - 1));
    // A byte leaves the buffer only on a tick that starts a frame: from IDLE, or chained at the end of STOP.
    assign pop     = tick_in && buf_vld && ((state == IDLE) || ((state == STOP) && bit_end));

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign buf_vld  = (count != '0);
    assign buf_dat  = mem[rd_ptr];
    assign tx_ready = (count != (PTR_W + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic       hold_vld;
    logic [7:0] hold_dat;

    assign buf_vld  = hold_vld;
    assign buf_dat  = hold_dat;
    assign tx_ready = !hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
            hold_dat <= 8'h00;
        end else if (push) begin
            hold_vld <= 1'b1;
            hold_dat <= tx_data;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    assign busy = (state != IDLE) || buf_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= 3'd0;
            shifter  <= 8'h00;
            dcom     <= 1'b1;
        end else begin
            if ((state != IDLE) && tick_in) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        shifter  <= buf_dat;
                        dcom     <= 1'b0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        dcom    <= shifter[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx != 3'd7) begin
                            shifter <= shifter >> 1;
                            dcom    <= shifter[1];
                            bit_idx <= bit_idx + 3'd1;
                        end else begin
                            dcom  <= 1'b1;
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shifter <= buf_dat;
                            dcom    <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line samples are logged once per tick strobe and decoded into frames.
module tb_uart_tx;

    localparam int TPB = 16;
    localparam int FRAME = 10 * TPB;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 5;
`else
    localparam int CAP = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_in = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dcom;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    bit         tick_en = 1'b0;
    bit         logging = 1'b0;
    logic       q_log[$];
    int         fstart[$];
    logic [7:0] fbyte[$];
    int         ferr;

    uart_tx #(.TICKS_PER_BIT(TPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dcom(dcom), .busy(busy)
    );

    always #5 clk = ~clk;

    // One strobe every third clock while enabled.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            if (tick_en && div >= 2) begin
                tick_in = 1'b1;
                div = 0;
            end else begin
                tick_in = 1'b0;
                if (tick_en) div++;
            end
        end
    end

    initial begin : line_mon
        logic t;
        forever begin
            @(posedge clk);
            t = tick_in;
            #1;
            if (t && logging) q_log.push_back(dcom);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", busy, 1'b0);
    endtask

    function automatic int first_zero();
        for (int i = 0; i < q_log.size(); i++) if (q_log[i] !== 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_zeros();
        int z;
        z = 0;
        for (int i = 0; i < q_log.size(); i++) if (q_log[i] !== 1'b1) z++;
        return z;
    endfunction

    task automatic decode();
        int i;
        logic v;
        logic [7:0] by;
        ferr = 0;
        fstart.delete();
        fbyte.delete();
        i = 0;
        while (i < q_log.size()) begin
            if (q_log[i] === 1'b1) begin
                i++;
                continue;
            end
            if (i + FRAME > q_log.size()) begin
                ferr++;
                break;
            end
            fstart.push_back(i);
            by = 8'h00;
            for (int b = 0; b < 10; b++) begin
                v = q_log[i + TPB * b];
                for (int k = 1; k < TPB; k++) if (q_log[i + TPB * b + k] !== v) ferr++;
                if (b == 0 && v !== 1'b0) ferr++;
                if (b == 9 && v !== 1'b1) ferr++;
                if (b >= 1 && b <= 8) by[b - 1] = v;
            end
            fbyte.push_back(by);
            i += FRAME;
        end
    endtask

    initial begin : main
        logic [9:0]  a5_bits;
        logic [15:0] vec;
        logic [7:0]  burst[CAP + 1];
        int acc, n, s, changes, l0;
        logic d0;
        bit reached;

        // Reset with the strobe running
        tick_en = 1'b1;
        logging = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dcom", dcom, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        repeat (97) @(negedge clk);
        check("rst_hold_zeros", count_zeros(), 0);
        check("rst_hold_dcom", dcom, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
        q_log.delete();
        a5_bits = 10'b11_0100_1010;
        push(8'hA5);
        check("busy_after_accept", busy, 1'b1);
        wait_idle();
        check("a5_idle_dcom", dcom, 1'b1);
        decode();
        check("a5_frames", fstart.size(), 1);
        if (fstart.size() == 1) begin
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < TPB; k++) vec[k] = q_log[fstart[0] + TPB * b + k];
                check($sformatf("a5_bit%0d", b), vec, a5_bits[b] ? 16'hFFFF : 16'h0000);
            end
        end

        // Back-to-back 0x00, 0xFF with no idle strobe
        q_log.delete();
        push(8'h00);
        push(8'hFF);
        wait_idle();
        decode();
        check("b2b_frames", fstart.size(), 2);
        check("b2b_ferr", ferr, 0);
        if (fstart.size() == 2) begin
            check("b2b_byte0", fbyte[0], 8'h00);
            check("b2b_byte1", fbyte[1], 8'hFF);
            check("b2b_gap", fstart[1] - fstart[0], FRAME);
        end

        // Backpressure: hold tx_valid over CAP+1 bytes
        q_log.delete();
        for (int k = 0; k <= CAP; k++) burst[k] = 8'h31 + 8'(k);
        acc = 0;
        @(negedge clk);
        tx_data  = burst[0];
        tx_valid = 1'b1;
        for (int c = 0; c < 4000 && acc <= CAP; c++) begin
            logic r;
            r = tx_ready;
            @(negedge clk);
            if (r) begin
                acc++;
                if (acc <= CAP) tx_data = burst[acc];
                else tx_valid = 1'b0;
            end
            if (c == 99) check("bp_accepted_window", acc, CAP);
        end
        tx_valid = 1'b0;
        check("bp_all_accepted", acc, CAP + 1);
        wait_idle();
        decode();
        check("bp_frames", fstart.size(), CAP + 1);
        check("bp_ferr", ferr, 0);
        for (int k = 0; k <= CAP && k < fbyte.size(); k++)
            check($sformatf("bp_order%0d", k), fbyte[k], burst[k]);

        // Reset during data bit 3 of 0x3C with bytes buffered
        q_log.delete();
        push(8'h3C);
        push(8'h11);
`ifdef UART_TX_FIFO_EN
        push(8'h22);
`endif
        reached = 1'b0;
        n = 0;
        while (!reached && n < 3000) begin
            @(negedge clk);
            n++;
            s = first_zero();
            if (s >= 0 && q_log.size() >= s + 72) reached = 1'b1;
        end
        check("rst_mid_reached_bit3", reached, 1'b1);
        check("rst_mid_pre_dcom", dcom, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dcom", dcom, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", tx_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        q_log.delete();
        repeat (400) @(negedge clk);
        check("rst_mid_no_frames", count_zeros(), 0);
        check("rst_mid_busy_after", busy, 1'b0);

        // Tick stall mid-bit
        q_log.delete();
        push(8'h5A);
        reached = 1'b0;
        n = 0;
        while (!reached && n < 3000) begin
            @(negedge clk);
            n++;
            s = first_zero();
            if (s >= 0 && q_log.size() >= s + 40) reached = 1'b1;
        end
        check("stall_reached", reached, 1'b1);
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        d0 = dcom;
        l0 = q_log.size();
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (dcom !== d0) changes++;
        end
        check("stall_dcom_frozen", changes, 0);
        check("stall_no_strobes", q_log.size(), l0);
        tick_en = 1'b1;
        wait_idle();
        decode();
        check("stall_frames", fstart.size(), 1);
        check("stall_ferr", ferr, 0);
        if (fbyte.size() == 1) check("stall_byte", fbyte[0], 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial byte transmitter that drives the `dcom` line consumed by the team's serial receiver. Bytes arrive over a valid/ready handshake and are buffered. Each byte is sent as one frame, LSB first: start bit (0), 8 data bits, stop bit (1). Bit timing comes from the shared oversampling strobe `tick_in`, so transmitter and receiver run from one baud generator.

## Interface
- `TICKS_PER_BIT`, 16: `tick_in` strobes per serial bit; legal range 2..64.
- `FIFO_DEPTH`, 4: buffer entries when `UART_TX_FIFO_EN` is defined; power of two, 2..16; ignored otherwise.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  single-`clk`-cycle baud strobe, synchronous to `clk`.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  buffer can accept a byte; a transfer occurs on a rising edge where `tx_valid && tx_ready`.
- `dcom`  out  1  serial line, registered, idles high.
- `busy`  out  1  high while a frame is on the line or any byte is buffered.

## Operation
- States: IDLE, START, DATA, STOP. State is held in a registered FSM, with a shifter, a 3-bit bit index, and a tick counter of width clog2(`TICKS_PER_BIT`).
- IDLE:
  - `dcom`=1.
  - On a `clk` edge with `tick_in`=1 and the buffer non-empty: pop the oldest byte into the shifter, set `dcom`<=0, clear the tick counter, go to START.
- In every active state, each `tick_in` cycle increments the tick counter. When the counter reaches `TICKS_PER_BIT`-1 on a tick, it wraps to 0 and a bit boundary occurs.
- START boundary: `dcom`<=shifter[0], bit index=0, go to DATA.
- DATA boundary:
  - If bit index < 7: shift right, `dcom`<=next bit, increment index.
  - If bit index = 7: `dcom`<=1, go to STOP.
- STOP boundary:
  - If the buffer is non-empty: pop, `dcom`<=0, go to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- Buffer without the FIFO: a single holding register. `tx_ready` = holding register empty. Combined with the shifter, this gives two bytes of capacity.
- `tx_ready` depends only on registered state, never on `tx_valid`.
- Push and pop in the same cycle:
  - Allowed when `tx_ready`=1; the occupancy count is unchanged.
  - When full, `tx_ready`=0, so a push in the same cycle as a pop is not accepted. `tx_ready` rises the cycle after the pop.
- `tx_data` is captured only on a transfer edge. Changes while `tx_ready`=0 are ignored.
- `busy` = (state != IDLE) or buffer non-empty.

## Timing
- Reset values: `dcom`=1, `tx_ready`=1, `busy`=0, state IDLE, buffer empty, counters 0.
- Reset asserted mid-frame: `dcom` returns to 1 immediately (asynchronously). The partial frame and all buffered bytes are discarded.
- Latency, accept to start bit:
  - `busy` rises the cycle after acceptance.
  - The start bit begins on the first `tick_in` edge after the byte is visible in the buffer, at least 1 `clk` after acceptance.
- Every bit, including the stop bit, lasts exactly `TICKS_PER_BIT` tick strobes. A frame lasts 10×`TICKS_PER_BIT` strobes.
- With `tick_in` held low, `dcom` and all counters freeze; the handshake still operates.
- `busy` falls on the STOP-to-IDLE edge.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - The holding register is replaced by a `FIFO_DEPTH`-entry circular FIFO with wrap-around read and write pointers.
  - `tx_ready` = not full. Total capacity is `FIFO_DEPTH`+1 bytes, counting the shifter.
- `UART_TX_FIFO_EN` undefined: single holding register, as described above. `FIFO_DEPTH` is unused.
- Line format and timing are identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 -> `dcom`=1, `tx_ready`=1, `busy`=0. Hold 100 cycles with `tick_in` running -> `dcom` stays 1.
- Single byte 0xA5, `TICKS_PER_BIT`=16 -> `dcom` carries 0,1,0,1,0,0,1,0,1,1, each held for exactly 16 strobes; then `busy`=0 and `dcom`=1.
- Back-to-back 0x00 then 0xFF -> 20 contiguous bit periods: 0, eight 0s, 1, 0, eight 1s, 1, with no idle strobe between frames.
- Backpressure, FIFO off: hold `tx_valid`=1 with 3 bytes -> first two accepted, `tx_ready`=0 until the first byte loads into the shifter, third accepted after that. FIFO on with `FIFO_DEPTH`=4 -> 5 bytes accepted before `tx_ready`=0; frames are sent in push order.
- Reset mid-frame: assert `rst_n` during data bit 3 of 0x3C with 2 bytes buffered -> `dcom`=1 immediately, `busy`=0, no further frames after release.
- Tick stall: gate `tick_in` low for 50 cycles mid-bit -> `dcom` is unchanged throughout; on resume, the remaining bit length equals the strobes that were still outstanding.
